// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, slave FSM state type and default word width.
package spi_pkg;

  // Mode encodings as {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int unsigned SPI_WIDTH = 8;

  typedef enum logic {
    IDLE,
    XFER
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third register for rise/fall detection of the synced level.
module spi_sync_edge #(
  parameter bit ResetVal = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {3{ResetVal}};
    end else begin
      sync_q <= {sync_q[1:0], d};
    end
  end

  assign q    = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI slave: oversampled sclk/cs_n/mosi, WIDTH-bit words in and out, single-entry tx buffer.
// Optional SPI_SLAVE_OVERRUN_EN adds rx_ack input and rx_overrun flag.
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH,
  parameter bit          CPOL  = 1'b0,
  parameter bit          CPHA  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic             rx_ack,
  output logic             rx_overrun
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, unused_cs_rise, cs_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;
  logic unused_sclk_s;

  spi_sync_edge #(.ResetVal(CPOL)) u_sync_sclk (
    .clk  (clk),
    .reset(reset),
    .d    (sclk),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.ResetVal(1'b1)) u_sync_cs (
    .clk  (clk),
    .reset(reset),
    .d    (cs_n),
    .q    (cs_s),
    .rise (unused_cs_rise),
    .fall (cs_fall)
  );

  spi_sync_edge #(.ResetVal(1'b0)) u_sync_mosi (
    .clk  (clk),
    .reset(reset),
    .d    (mosi),
    .q    (mosi_s),
    .rise (unused_mosi_rise),
    .fall (unused_mosi_fall)
  );

  assign unused_sclk_s = sclk_s;

  spi_state_t       state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic             tx_ready_q, tx_ready_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q;
  logic             sample_edge, shift_edge, word_done, load_shift;

  always_comb begin
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    unique case ({CPOL, CPHA})
      SPI_MODE0: begin sample_edge = sclk_rise; shift_edge = sclk_fall; end
      SPI_MODE1: begin sample_edge = sclk_fall; shift_edge = sclk_rise; end
      SPI_MODE2: begin sample_edge = sclk_fall; shift_edge = sclk_rise; end
      SPI_MODE3: begin sample_edge = sclk_rise; shift_edge = sclk_fall; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    word_done  = 1'b0;
    load_shift = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A sclk edge coincident with the cs_n fall is deliberately ignored.
        if (cs_fall) begin
          state_d    = XFER;
          load_shift = 1'b1;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end
      end
      XFER: begin
        if (cs_s) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end else if (sample_edge) begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
          if (bit_cnt_q == CntW'(WIDTH - 1)) begin
            word_done  = 1'b1;
            load_shift = 1'b1;
            rx_data_d  = rx_shift_d;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (shift_edge && bit_cnt_q != '0) begin
          // A shift edge before the word's first sample keeps the MSB on miso.
          tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
        end
      end
    endcase

    if (load_shift) begin
      tx_shift_d = tx_ready_q ? '0 : tx_buf_q;
      tx_ready_d = 1'b1;
      if (tx_load) begin
        tx_buf_d   = tx_data;
        tx_ready_d = 1'b0;
      end
    end else if (tx_load && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_ready_q <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= word_done;
    end
  end

  assign miso     = (state_q == XFER) ? tx_shift_q[WIDTH-1] : 1'b0;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic unread_q, unread_d;
  logic overrun_q, overrun_d;

  always_comb begin
    unread_d  = unread_q;
    overrun_d = overrun_q;
    if (rx_ack) begin
      unread_d  = 1'b0;
      overrun_d = 1'b0;
    end
    if (word_done) begin
      if (unread_q && !rx_ack) overrun_d = 1'b1;
      unread_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      unread_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      unread_q  <= unread_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench: mode-0 and mode-3 slaves driven by a bench SPI master, rx words scoreboarded.
module tb_spi_slave_rx_tx;
  localparam int HALF = 80;  // sclk half period; clk period is 10

  logic       clk, reset, mosi;
  logic       sclk0, cs0, miso0, tx_load0, tx_ready0, rx_valid0;
  logic       sclk3, cs3, miso3, tx_load3, tx_ready3, rx_valid3;
  logic [7:0] tx_data, rx_data0, rx_data3;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_ack0, rx_ovr0, rx_ack3, rx_ovr3;
`endif

  int total = 0;
  int bad = 0;
  int rx_cnt0 = 0;
  int rx_cnt3 = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q3[$];
  logic [7:0] r1, r2;

  spi_slave_rx_tx #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .sclk(sclk0), .cs_n(cs0), .mosi(mosi), .miso(miso0),
    .tx_data(tx_data), .tx_load(tx_load0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .rx_ack(rx_ack0), .rx_overrun(rx_ovr0)
`endif
  );

  spi_slave_rx_tx #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
    .clk(clk), .reset(reset), .sclk(sclk3), .cs_n(cs3), .mosi(mosi), .miso(miso3),
    .tx_data(tx_data), .tx_load(tx_load3), .tx_ready(tx_ready3),
    .rx_data(rx_data3), .rx_valid(rx_valid3)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .rx_ack(rx_ack3), .rx_overrun(rx_ovr3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input bit m3, input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    if (m3) tx_load3 = 1'b1; else tx_load0 = 1'b1;
    @(negedge clk);
    tx_load0 = 1'b0;
    tx_load3 = 1'b0;
  endtask

  // Bench master: drives mosi MSB first, captures miso just before each sample edge.
  task automatic spi_xfer(input bit m3, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!m3) begin
        mosi = tx[i];
        #(HALF);
        rx[i] = miso0;
        sclk0 = 1'b1;
        #(HALF);
        sclk0 = 1'b0;
      end else begin
        sclk3 = 1'b0;
        mosi  = tx[i];
        #(HALF);
        rx[i] = miso3;
        sclk3 = 1'b1;
        #(HALF);
      end
    end
  endtask

  // Scoreboard: every rx_valid pulse must match the oldest queued word.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid0) begin
        rx_cnt0++;
        if (exp_q0.size() == 0) check("rx0_unexpected", 32'(rx_valid0), 32'd0);
        else check("rx0_data", 32'(rx_data0), 32'(exp_q0.pop_front()));
      end
      if (rx_valid3) begin
        rx_cnt3++;
        if (exp_q3.size() == 0) check("rx3_unexpected", 32'(rx_valid3), 32'd0);
        else check("rx3_data", 32'(rx_data3), 32'(exp_q3.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0;
    mosi = 1'b0; tx_data = '0;
    sclk0 = 1'b0; cs0 = 1'b1; tx_load0 = 1'b0;
    sclk3 = 1'b1; cs3 = 1'b1; tx_load3 = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    rx_ack0 = 1'b0; rx_ack3 = 1'b0;
`endif
    wait_clk(3);
    check("rst_miso0", 32'(miso0), 32'd0);
    check("rst_tx_ready0", 32'(tx_ready0), 32'd1);
    check("rst_rx_data0", 32'(rx_data0), 32'd0);
    check("rst_rx_valid0", 32'(rx_valid0), 32'd0);
    check("rst_miso3", 32'(miso3), 32'd0);
    check("rst_tx_ready3", 32'(tx_ready3), 32'd1);
    reset = 1'b1;
    wait_clk(4);

    // Mode 0 single word with a preloaded tx word
    load(1'b0, 8'hA5);
    check("m0_tx_ready_after_load", 32'(tx_ready0), 32'd0);
    cs0 = 1'b0;
    wait_clk(5);
    check("m0_tx_ready_after_cs", 32'(tx_ready0), 32'd1);
    exp_q0.push_back(8'h3C);
    spi_xfer(1'b0, 8'h3C, 8, r1);
    check("m0_miso_word", 32'(r1), 32'hA5);
    wait_clk(10);
    cs0 = 1'b1;
    wait_clk(10);
    check("m0_rx_pulses", 32'(rx_cnt0), 32'd1);

    // Mode 3 back-to-back words, second tx word loaded mid-first-word
    load(1'b1, 8'h96);
    cs3 = 1'b0;
    wait_clk(8);
    exp_q3.push_back(8'h81);
    exp_q3.push_back(8'h7E);
    fork
      spi_xfer(1'b1, 8'h81, 8, r1);
      begin
        #(HALF * 6);
        load(1'b1, 8'h55);
      end
    join
    spi_xfer(1'b1, 8'h7E, 8, r2);
    check("m3_miso_word1", 32'(r1), 32'h96);
    check("m3_miso_word2", 32'(r2), 32'h55);
    wait_clk(10);
    cs3 = 1'b1;
    wait_clk(10);
    check("m3_rx_pulses", 32'(rx_cnt3), 32'd2);
    check("m3_rx_data_last", 32'(rx_data3), 32'h7E);

    // Underrun: no tx word queued, miso stays low
    cs0 = 1'b0;
    wait_clk(8);
    exp_q0.push_back(8'hFF);
    spi_xfer(1'b0, 8'hFF, 8, r1);
    check("underrun_miso", 32'(r1), 32'h00);
    wait_clk(10);
    cs0 = 1'b1;
    wait_clk(10);
    check("underrun_tx_ready", 32'(tx_ready0), 32'd1);
    check("underrun_rx_pulses", 32'(rx_cnt0), 32'd2);

    // Abort after 5 bits, then a clean word
    cs0 = 1'b0;
    wait_clk(8);
    spi_xfer(1'b0, 8'hC3, 5, r1);
    wait_clk(4);
    cs0 = 1'b1;
    wait_clk(20);
    check("abort_rx_pulses", 32'(rx_cnt0), 32'd2);
    check("abort_rx_data_kept", 32'(rx_data0), 32'hFF);
    cs0 = 1'b0;
    wait_clk(8);
    exp_q0.push_back(8'h12);
    spi_xfer(1'b0, 8'h12, 8, r1);
    wait_clk(10);
    cs0 = 1'b1;
    wait_clk(10);
    check("after_abort_rx_pulses", 32'(rx_cnt0), 32'd3);

    // Reset mid-transfer at bit 4
    load(1'b0, 8'h0F);
    cs0 = 1'b0;
    wait_clk(8);
    spi_xfer(1'b0, 8'h44, 4, r1);
    load(1'b0, 8'h33);
    wait_clk(4);
    check("pre_reset_miso", 32'(miso0), 32'd1);
    check("pre_reset_tx_ready", 32'(tx_ready0), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset_miso", 32'(miso0), 32'd0);
    check("mid_reset_tx_ready", 32'(tx_ready0), 32'd1);
    check("mid_reset_rx_data", 32'(rx_data0), 32'd0);
    check("mid_reset_rx_valid", 32'(rx_valid0), 32'd0);
    cs0 = 1'b1;
    wait_clk(4);
    reset = 1'b1;
    wait_clk(4);
    cs0 = 1'b0;
    wait_clk(8);
    exp_q0.push_back(8'h99);
    spi_xfer(1'b0, 8'h99, 8, r1);
    wait_clk(10);
    cs0 = 1'b1;
    wait_clk(10);
    check("post_reset_rx_data", 32'(rx_data0), 32'h99);
    check("post_reset_rx_pulses", 32'(rx_cnt0), 32'd4);

`ifdef SPI_SLAVE_OVERRUN_EN
    @(negedge clk); rx_ack0 = 1'b1; @(negedge clk); rx_ack0 = 1'b0;
    check("ovr_cleared_start", 32'(rx_ovr0), 32'd0);
    cs0 = 1'b0;
    wait_clk(8);
    exp_q0.push_back(8'h01);
    exp_q0.push_back(8'h02);
    spi_xfer(1'b0, 8'h01, 8, r1);
    spi_xfer(1'b0, 8'h02, 8, r2);
    wait_clk(10);
    cs0 = 1'b1;
    wait_clk(10);
    check("ovr_set", 32'(rx_ovr0), 32'd1);
    check("ovr_rx_data", 32'(rx_data0), 32'h02);
    @(negedge clk); rx_ack0 = 1'b1; @(negedge clk); rx_ack0 = 1'b0;
    check("ovr_cleared", 32'(rx_ovr0), 32'd0);
`endif

    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q3_drained", 32'(exp_q3.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
